sepia_writeback: RTL

Write-side counterpart to the sepia frame reader: accepts processed pixels from the sepia filter's `ap_done` strobe and stores them into three output BRAMs (R, G, B) at sequential addresses. Sits between the sepia filter outputs and single-port result BRAMs. The BRAMs' port is shared with a host readback requester that has priority, so pixels are buffered in a small FIFO while readback holds the port.

---
 rtl/sepia_pkg.sv | 16 +
 rtl/sepia_writeback_fifo.sv | 62 ++++++
 rtl/sepia_writeback.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sepia_pkg.sv
// Shared types for the sepia writeback path: FSM encoding and the packed RGB pixel.
package sepia_pkg;
    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } pixel_t;
endpackage

// File: rtl/sepia_writeback_fifo.sv
// Small show-ahead synchronous FIFO; dout is the head entry whenever empty is low.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_eff, pop_eff;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign dout     = mem_q[rd_ptr_q];
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_eff && !pop_eff)      count_d = count_q + 1'b1;
            else if (pop_eff && !push_eff) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff && !flush) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/sepia_writeback.sv
// Buffers filtered pixels and writes them to the R/G/B result BRAMs in address order,
// yielding the shared BRAM port to host readback whenever it is requested.
module sepia_writeback
    import sepia_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int NUM_PIXELS = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              px_valid,
    input  logic [PIX_W-1:0]  new_red,
    input  logic [PIX_W-1:0]  new_green,
    input  logic [PIX_W-1:0]  new_blue,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [PIX_W-1:0]  bram_din_r,
    output logic [PIX_W-1:0]  bram_din_g,
    output logic [PIX_W-1:0]  bram_din_b,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);
    localparam logic [ADDR_W:0] NUM_C  = (ADDR_W+1)'(NUM_PIXELS);
    localparam logic [ADDR_W:0] LAST_C = NUM_C - 1'b1;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   push_cnt_q, push_cnt_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic              overflow_q, overflow_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              bram_en_q, bram_en_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    pixel_t            din_q, din_d;

    pixel_t fifo_dout, new_px, wr_px;
    logic   fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic   in_run, can_take, pop_go, accept;

    pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(pixel_t))) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (new_px),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign new_px = '{r: new_red, g: new_green, b: new_blue};
    // An arriving pixel bypasses an empty FIFO so it is written on the very next cycle.
    assign wr_px  = fifo_empty ? new_px : fifo_dout;

    always_comb begin
        state_d      = state_q;
        push_cnt_d   = push_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        bram_en_d    = 1'b0;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        din_d        = din_q;
        fifo_flush   = 1'b0;

        in_run    = (state_q == ST_RUN);
        can_take  = in_run && px_valid && (push_cnt_q < NUM_C);
        pop_go    = in_run && !rd_req && (wr_cnt_q < NUM_C) && (!fifo_empty || can_take);
        accept    = can_take && (!fifo_full || pop_go);
        fifo_pop  = pop_go && !fifo_empty;
        fifo_push = accept && !(pop_go && fifo_empty);

        if (accept)               push_cnt_d = push_cnt_q + 1'b1;
        if (can_take && !accept)  overflow_d = 1'b1;

        if (pop_go) begin
            bram_en_d   = 1'b1;
            bram_we_d   = 1'b1;
            bram_addr_d = wr_cnt_q[ADDR_W-1:0];
            din_d       = wr_px;
            wr_cnt_d    = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_C) state_d = ST_DONE;
        end

        if (rd_req) begin
            bram_en_d   = 1'b1;
            bram_we_d   = 1'b0;
            bram_addr_d = rd_addr;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    wr_cnt_d   = '0;
                    push_cnt_d = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                fifo_flush   = 1'b1;
                state_d      = ST_IDLE;
            end
            default: ;
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            push_cnt_q   <= '0;
            wr_cnt_q     <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            push_cnt_q   <= push_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            din_q        <= din_d;
        end
    end

    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_din_r = din_q.r;
    assign bram_din_g = din_q.g;
    assign bram_din_b = din_q.b;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
endmodule
